// File: rtl/latch_dump_tx_pkg.sv
// rtl/latch_dump_tx_pkg.sv - shared types and constants for the pipeline latch dump serializer
// FSM encoding, widths and the baud-rate divider derivation used by the top and the UART.
package latch_dump_tx_pkg;

  localparam int LATCH_SEL_W    = 7;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;
  // One extra bit so the word counter can reach NUM_WORDS itself (PC + every mux word).
  localparam int WORD_IDX_W     = LATCH_SEL_W + 1;
  localparam int FRAME_BITS     = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_PC  = 3'd1,
    SEL      = 3'd2,
    WAIT_MUX = 3'd3,
    CAPTURE  = 3'd4,
    SEND     = 3'd5,
    WAIT_TX  = 3'd6,
    NEXT     = 3'd7
  } dumpState_t;

  function automatic int clksPerBit(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

endpackage

// File: rtl/latch_dump_tx_if.sv
// rtl/latch_dump_tx_if.sv - debug dump bus between the halted pipeline and the serializer
// The slave side is the serializer; the master side is the pipeline/debug harness.
interface latch_dump_tx_if;
  import latch_dump_tx_pkg::*;

  logic                   start;
  logic [31:0]            inPC;
  logic [31:0]            inLatch;
  logic [LATCH_SEL_W-1:0] outControlLatchMux;
  logic                   TX;
  logic                   busy;
  logic                   done;

  modport master (
    output start, inPC, inLatch,
    input  outControlLatchMux, TX, busy, done
  );

  modport slave (
    input  start, inPC, inLatch,
    output outControlLatchMux, TX, busy, done
  );

endinterface

// File: rtl/latch_dump_tx_uart_tx.sv
// rtl/latch_dump_tx_uart_tx.sv - 8N1 UART transmitter with baud and bit counters
// tx_start is ignored while a frame is in flight; tx_done pulses in the last stop-bit clock.
module uart_tx
  import latch_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        STOP_BIT  = 4'(FRAME_BITS - 1);

  logic              active;
  logic [BAUD_W-1:0] baudCnt;
  logic [3:0]        bitCnt;
  logic [7:0]        shiftReg;
  logic              bitEnd;

  assign bitEnd  = active && (baudCnt == BAUD_LAST);
  assign tx_done = bitEnd && (bitCnt == STOP_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      baudCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      TX       <= 1'b1;
    end else if (!active) begin
      if (tx_start) begin
        active   <= 1'b1;
        baudCnt  <= '0;
        bitCnt   <= '0;
        shiftReg <= tx_data;
        TX       <= 1'b0;
      end
    end else if (bitEnd) begin
      baudCnt <= '0;
      if (bitCnt == STOP_BIT) begin
        active <= 1'b0;
      end else begin
        // Ones shift in behind the data, so after eight data bits the line falls to the stop level.
        bitCnt   <= bitCnt + 4'd1;
        TX       <= shiftReg[0];
        shiftReg <= {1'b1, shiftReg[7:1]};
      end
    end else begin
      baudCnt <= baudCnt + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/latch_dump_tx.sv
// rtl/latch_dump_tx.sv - dumps the PC and every pipeline latch word over UART after halt
// Word/byte sequencing FSM plus the word register; bit timing lives in uart_tx.
module latch_dump_tx
  import latch_dump_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 9600,
  parameter int NUM_WORDS = 40
) (
  input logic            clk,
  input logic            rst,
  latch_dump_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD);
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(NUM_WORDS);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  dumpState_t             state;
  dumpState_t             nextState;
  logic [31:0]            wordQ;
  logic [BYTE_IDX_W-1:0]  byteIdx;
  logic [WORD_IDX_W-1:0]  wordIdx;
  logic [LATCH_SEL_W-1:0] muxSel;
  logic                   txStart;
  logic                   txDone;
  logic [7:0]             txData;
  logic                   lastWord;
  logic                   accept;

  // The final NEXT cycle already reports not-busy, so it can take a new start like IDLE does.
  assign lastWord = (state == NEXT) && (wordIdx == LAST_WORD);
  assign accept   = bus.start && ((state == IDLE) || lastWord);
  assign txData   = wordQ[{byteIdx, 3'b000} +: 8];
  assign bus.outControlLatchMux = muxSel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (accept) nextState = LOAD_PC;
      LOAD_PC:  nextState = SEND;
      SEL:      nextState = WAIT_MUX;
      WAIT_MUX: nextState = CAPTURE;
      CAPTURE:  nextState = SEND;
      SEND:     nextState = WAIT_TX;
      WAIT_TX: begin
        if (txDone) begin
          nextState = (byteIdx == LAST_BYTE) ? NEXT : SEND;
        end
      end
      NEXT: begin
        if (lastWord) begin
          nextState = accept ? LOAD_PC : IDLE;
        end else begin
          nextState = SEL;
        end
      end
      default:  nextState = IDLE;
    endcase
  end

  always_comb begin
    txStart  = (state == SEND);
    bus.done = lastWord;
    bus.busy = !((state == IDLE) || lastWord);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordQ   <= '0;
      byteIdx <= '0;
      wordIdx <= '0;
      muxSel  <= '0;
    end else begin
      if (accept) begin
        wordQ <= bus.inPC;
      end
      case (state)
        LOAD_PC: begin
          byteIdx <= '0;
          wordIdx <= '0;
        end
        // Word 0 is the PC, so mux index lags the word counter by one.
        SEL: muxSel <= LATCH_SEL_W'(wordIdx - WORD_IDX_W'(1));
        CAPTURE: begin
          wordQ   <= bus.inLatch;
          byteIdx <= '0;
        end
        WAIT_TX: begin
          if (txDone && (byteIdx != LAST_BYTE)) begin
            byteIdx <= byteIdx + BYTE_IDX_W'(1);
          end
        end
        NEXT: begin
          if (!lastWord) begin
            wordIdx <= wordIdx + WORD_IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTx (
    .clk      (clk),
    .rst      (rst),
    .tx_start (txStart),
    .tx_data  (txData),
    .tx_done  (txDone),
    .TX       (bus.TX)
  );

endmodule

// File: tb/tb_latch_dump_tx.sv
// tb/tb_latch_dump_tx.sv - self-checking bench for the latch dump serializer
// Waveform model built from the dump timing rules, compared every cycle, plus a UART decoder.
module tb_latch_dump_tx;
  import latch_dump_tx_pkg::*;

  localparam int CLK_FREQ  = 16;
  localparam int BAUD      = 1;
  localparam int NUM_WORDS = 2;
  localparam int CPB       = CLK_FREQ / BAUD;
  localparam int NBYTES    = 4 * (NUM_WORDS + 1);

  typedef struct packed {
    logic                   tx;
    logic                   busy;
    logic                   done;
    logic [LATCH_SEL_W-1:0] mux;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  latch_dump_tx_if bus();

  latch_dump_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .NUM_WORDS (NUM_WORDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total     = 0;
  int   bad       = 0;
  int   doneCount = 0;
  int   rstEpoch  = 0;
  ent_t expQ[$];
  logic [7:0] rxQ[$];
  logic [LATCH_SEL_W-1:0] curMux = '0;
  logic [31:0] latchBase = 32'hA5A50000;
  logic wiggle = 1'b0;
  logic [7:0] lit [NBYTES] = '{8'h40, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'hA5, 8'hA5,
                               8'h01, 8'h00, 8'hA5, 8'hA5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushN(input logic tx, input logic busy, input logic done, input int n);
    ent_t e;
    e.tx = tx; e.busy = busy; e.done = done; e.mux = curMux;
    for (int i = 0; i < n; i++) expQ.push_back(e);
  endtask

  // Expected line/busy/done/mux for every cycle after an accepted start.
  task automatic buildTrace(input logic [31:0] pc);
    logic [31:0] w;
    logic [9:0]  frame;
    pushN(1'b1, 1'b1, 1'b0, 2);
    for (int wi = 0; wi <= NUM_WORDS; wi++) begin
      w = (wi == 0) ? pc : latchBase + 32'(wi - 1);
      for (int bi = 0; bi < 4; bi++) begin
        frame = {1'b1, w[8*bi +: 8], 1'b0};
        for (int k = 0; k < 10; k++) pushN(frame[k], 1'b1, 1'b0, CPB);
        if (bi < 3) pushN(1'b1, 1'b1, 1'b0, 1);
      end
      if (wi < NUM_WORDS) begin
        pushN(1'b1, 1'b1, 1'b0, 2);
        curMux = LATCH_SEL_W'(wi);
        pushN(1'b1, 1'b1, 1'b0, 3);
      end
    end
    pushN(1'b1, 1'b0, 1'b1, 1);
  endtask

  function automatic logic [7:0] expByte(input logic [31:0] pc, input int idx);
    logic [31:0] w;
    w = (idx / 4 == 0) ? pc : latchBase + 32'(idx / 4 - 1);
    return w[8*(idx%4) +: 8];
  endfunction

  // Per-cycle compare against the waveform model.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        expQ.delete();
        curMux = '0;
        chk("rst_tx",   32'(bus.TX),   32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mux",  32'(bus.outControlLatchMux), 32'd0);
      end else begin
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
        end else begin
          e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.mux = curMux;
        end
        chk("cyc_tx",   32'(bus.TX),   32'(e.tx));
        chk("cyc_busy", 32'(bus.busy), 32'(e.busy));
        chk("cyc_done", 32'(bus.done), 32'(e.done));
        chk("cyc_mux",  32'(bus.outControlLatchMux), 32'(e.mux));
        if (bus.done) doneCount++;
        if (bus.start && !e.busy) buildTrace(bus.inPC);
      end
    end
  end

  // UART receiver sampling mid-bit; frames cut by reset are dropped.
  initial begin
    logic [7:0] rb;
    logic       stopBit;
    int         ep;
    forever begin
      @(negedge clk);
      if (!rst && bus.TX === 1'b0) begin
        ep = rstEpoch;
        repeat (CPB / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rb[i] = bus.TX;
        end
        repeat (CPB) @(negedge clk);
        stopBit = bus.TX;
        if (ep == rstEpoch && !rst) begin
          chk("rx_stop", 32'(stopBit), 32'd1);
          rxQ.push_back(rb);
        end
      end
    end
  end

  // Registered latch mux: data follows the select by one clock.
  initial begin
    logic [LATCH_SEL_W-1:0] selS;
    forever begin
      @(negedge clk);
      selS = bus.outControlLatchMux;
      @(posedge clk);
      #1;
      bus.inLatch = latchBase + 32'(selS);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulseStart(input logic [31:0] pc);
    @(posedge clk); #1;
    bus.inPC  = pc;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic measureFirstStart(input string name);
    int   k    = 0;
    logic fell = 1'b0;
    while (k < 10 && !fell) begin
      @(negedge clk);
      k++;
      if (bus.TX === 1'b0) fell = 1'b1;
    end
    chk(name, 32'(k), 32'd3);
  endtask

  task automatic waitDone(input string name);
    logic seen = 1'b0;
    for (int c = 0; c < 2500 && !seen; c++) begin
      @(posedge clk); #1;
      if (wiggle) bus.inPC = $urandom;
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic checkRx(input string name, input logic [31:0] pc, input logic useLit);
    chk({name, "_count"}, 32'(rxQ.size()), 32'(NBYTES));
    for (int i = 0; i < NBYTES && i < rxQ.size(); i++) begin
      chk({name, "_byte"}, 32'(rxQ[i]), 32'(useLit ? lit[i] : expByte(pc, i)));
    end
  endtask

  initial begin
    logic [31:0] pc;
    bus.start   = 1'b0;
    bus.inPC    = '0;
    bus.inLatch = '0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(posedge clk);

    // Full dump with a rejected start in the middle.
    rxQ.delete();
    pulseStart(32'h00000040);
    measureFirstStart("first_start_gap");
    repeat (600) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    waitDone("dump1");
    checkRx("dump1", 32'h40, 1'b1);

    // Start held through the dump: accepted only in the done cycle.
    repeat (10) @(posedge clk);
    rxQ.delete();
    pulseStart(32'h00000040);
    measureFirstStart("dump2_start_gap");
    repeat (1500) @(posedge clk);
    #1 bus.start = 1'b1;
    waitDone("dump2");
    checkRx("dump2", 32'h40, 1'b1);
    rxQ.delete();
    @(posedge clk); #1 bus.start = 1'b0;
    measureFirstStart("b2b_start_gap");
    waitDone("dump3");
    checkRx("dump3", 32'h40, 1'b1);

    // Reset inside byte 5, data bit region.
    repeat (10) @(posedge clk);
    rxQ.delete();
    pulseStart(32'h00000040);
    measureFirstStart("rst_dump_start_gap");
    repeat (715) @(posedge clk);
    #1 rst = 1'b1;
    rstEpoch++;
    #1;
    chk("rst_mid_tx",   32'(bus.TX),   32'd1);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    chk("rst_mid_bytes", 32'(rxQ.size()), 32'd4);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(posedge clk);
    rxQ.delete();
    pc = $urandom;
    pulseStart(pc);
    measureFirstStart("post_rst_start_gap");
    waitDone("dump4");
    checkRx("dump4", pc, 1'b0);

    // Randomized PCs and latch contents, PC changing while busy.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 20)) @(posedge clk);
      latchBase = $urandom;
      pc        = $urandom;
      rxQ.delete();
      pulseStart(pc);
      wiggle = 1'b1;
      measureFirstStart("rand_start_gap");
      waitDone("rand");
      wiggle = 1'b0;
      checkRx("rand", pc, 1'b0);
    end

    repeat (20) @(posedge clk);
    chk("done_count", 32'(doneCount), 32'd7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
